// File: rtl/frame_uart_streamer_pkg.sv
// Shared constants and FSM encodings for the frame-to-UART streamer.
package frame_uart_streamer_pkg;

  localparam int BYTES_PER_FRAME_DEF = 9216;   // 96x96 greyscale
  localparam int ADDR_W_DEF          = 15;

  // Resync pair the host looks for when the frame header is enabled
  localparam logic [7:0] HDR_BYTE0 = 8'hAA;
  localparam logic [7:0] HDR_BYTE1 = 8'h55;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HDR0    = 4'd1,
    S_HDR1    = 4'd2,
    S_FETCH   = 4'd3,
    S_LATCH   = 4'd4,
    S_SEND    = 4'd5,
    S_WAIT_HI = 4'd6,
    S_WAIT_LO = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  // Which byte the shared SEND/WAIT handshake is currently carrying
  typedef enum logic [1:0] {
    PH_HDR0 = 2'd0,
    PH_HDR1 = 2'd1,
    PH_PIX  = 2'd2
  } phase_t;

endpackage

// File: rtl/frame_uart_streamer.sv
// Drains one frame from the frame-buffer RAM into the UART Tx, one byte per
// Tx busy cycle. Optional feature: define FRAME_HEADER_EN to prefix each
// frame with the 0xAA,0x55 resync pair.
module frame_uart_streamer
  import frame_uart_streamer_pkg::*;
#(
  parameter int BYTES_PER_FRAME = BYTES_PER_FRAME_DEF,
  parameter int ADDR_W          = ADDR_W_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Frame_Ready,
  output logic              o_Rd_En,
  output logic [ADDR_W-1:0] o_Rd_Addr,
  input  logic [7:0]        i_Rd_Data,
  output logic              o_Tx_Start,
  output logic [7:0]        o_Tx_Data,
  input  logic              i_Tx_Busy,
  output logic              o_Busy,
  output logic              o_Frame_Done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);

`ifdef FRAME_HEADER_EN
  localparam state_t FIRST_STATE = S_HDR0;
  localparam phase_t FIRST_PHASE = PH_HDR0;
`else
  localparam state_t FIRST_STATE = S_FETCH;
  localparam phase_t FIRST_PHASE = PH_PIX;
`endif

  state_t            state, state_nxt;
  phase_t            phase;
  logic [ADDR_W-1:0] addr;
  logic              accept;   // frame accepted this cycle
  logic              step;     // advance to next pixel address

  assign o_Rd_Addr = addr;

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and strobe outputs; strobes are pure decodes of state so a
  // reset edge drops any pending start immediately
  always_comb begin
    state_nxt    = state;
    o_Rd_En      = 1'b0;
    o_Tx_Start   = 1'b0;
    o_Frame_Done = 1'b0;
    accept       = 1'b0;
    step         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_Frame_Ready) begin
          accept    = 1'b1;
          state_nxt = FIRST_STATE;
        end
      end
      S_HDR0, S_HDR1: state_nxt = S_SEND;
      S_FETCH: begin
        o_Rd_En   = 1'b1;
        state_nxt = S_LATCH;
      end
      S_LATCH: state_nxt = S_SEND;
      S_SEND: begin
        // Tx may still be busy with someone else's byte: hold off
        if (!i_Tx_Busy) begin
          o_Tx_Start = 1'b1;
          state_nxt  = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (i_Tx_Busy) state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!i_Tx_Busy) begin
          case (phase)
            PH_HDR0: state_nxt = S_HDR1;
            PH_HDR1: state_nxt = S_FETCH;
            default: begin
              if (addr == LAST_ADDR) state_nxt = S_DONE;
              else begin
                step      = 1'b1;
                state_nxt = S_FETCH;
              end
            end
          endcase
        end
      end
      S_DONE: begin
        o_Frame_Done = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: address counter, Tx byte holding register, busy flag, phase
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      addr      <= '0;
      o_Tx_Data <= '0;
      o_Busy    <= 1'b0;
      phase     <= PH_PIX;
    end else begin
      if (accept) begin
        o_Busy <= 1'b1;
        addr   <= '0;
        phase  <= FIRST_PHASE;
      end
      if (step) addr <= addr + ADDR_W'(1);
      case (state)
        S_HDR0:  o_Tx_Data <= HDR_BYTE0;
        S_HDR1: begin
          o_Tx_Data <= HDR_BYTE1;
          phase     <= PH_HDR1;
        end
        S_FETCH: phase     <= PH_PIX;
        S_LATCH: o_Tx_Data <= i_Rd_Data;
        S_DONE:  o_Busy    <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Randomized bench for frame_uart_streamer: RAM model (data=addr[7:0]),
// Tx model with random busy length, and a byte-index scoreboard.
module tb_frame_uart_streamer;

  localparam int BPF  = 300;
  localparam int AW   = 15;
`ifdef FRAME_HEADER_EN
  localparam int HDR  = 2;
`else
  localparam int HDR  = 0;
`endif
  localparam int TOTAL = BPF + HDR;

  logic i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  logic          i_Rst, ready, ready1, ext_busy;
  logic          rd_en, tx_start, tx_busy, busy, done;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data, tx_data;
  logic          rd_en1, tx_start1, tx_busy1, busy1, done1;
  logic [AW-1:0] rd_addr1;
  logic [7:0]    rd_data1, tx_data1;

  frame_uart_streamer #(.BYTES_PER_FRAME(BPF), .ADDR_W(AW)) u_dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Frame_Ready(ready),
    .o_Rd_En(rd_en), .o_Rd_Addr(rd_addr), .i_Rd_Data(rd_data),
    .o_Tx_Start(tx_start), .o_Tx_Data(tx_data), .i_Tx_Busy(tx_busy),
    .o_Busy(busy), .o_Frame_Done(done));

  frame_uart_streamer #(.BYTES_PER_FRAME(1), .ADDR_W(AW)) u_one (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Frame_Ready(ready1),
    .o_Rd_En(rd_en1), .o_Rd_Addr(rd_addr1), .i_Rd_Data(rd_data1),
    .o_Tx_Start(tx_start1), .o_Tx_Data(tx_data1), .i_Tx_Busy(tx_busy1),
    .o_Busy(busy1), .o_Frame_Done(done1));

  // RAM models: data = address low byte one cycle after read enable, junk otherwise
  always @(posedge i_Clk) rd_data  <= rd_en  ? rd_addr[7:0]  : 8'($urandom);
  always @(posedge i_Clk) rd_data1 <= rd_en1 ? rd_addr1[7:0] : 8'($urandom);

  // Tx models: busy rises the cycle after start and stays high for a while
  int tx_cnt = 0, tx_cnt1 = 0;
  always @(posedge i_Clk) begin
    if (tx_start && !i_Rst) tx_cnt <= $urandom_range(12, 3);
    else if (tx_cnt > 0)    tx_cnt <= tx_cnt - 1;
  end
  always @(posedge i_Clk) begin
    if (tx_start1 && !i_Rst) tx_cnt1 <= 10;
    else if (tx_cnt1 > 0)    tx_cnt1 <= tx_cnt1 - 1;
  end
  assign tx_busy  = (tx_cnt != 0) || ext_busy;
  assign tx_busy1 = (tx_cnt1 != 0);

  int vec_cnt = 0, err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected byte on the line at position idx within a frame
  function automatic logic [7:0] exp_byte(input int idx);
    if (idx < HDR) return (idx == 0) ? 8'hAA : 8'h55;
    return 8'((idx - HDR) % 256);
  endfunction

  // Scoreboards
  int line_idx = 0, rd_idx = 0, n_start = 0, n_done = 0, n_rd = 0;
  int line1 = 0, n_st1 = 0, n_done1 = 0, n_rd1 = 0;

  initial begin
    forever begin
      @(negedge i_Clk);
      if (i_Rst) begin
        line_idx = 0; rd_idx = 0; line1 = 0;
      end else begin
        if (rd_en) begin
          chk("rd_addr", 32'(rd_addr), rd_idx);
          chk("rd_order", line_idx, rd_idx + HDR);
          rd_idx++; n_rd++;
        end
        if (tx_start) begin
          chk("start_while_busy", 32'(tx_busy), 0);
          chk("tx_data", 32'(tx_data), 32'(exp_byte(line_idx)));
          chk("busy_in_frame", 32'(busy), 1);
          line_idx++; n_start++;
        end
        if (done) begin
          chk("bytes_per_frame", line_idx, TOTAL);
          chk("reads_per_frame", rd_idx, BPF);
          line_idx = 0; rd_idx = 0; n_done++;
        end
        if (rd_en1) begin
          chk("one_rd_addr", 32'(rd_addr1), 0);
          n_rd1++;
        end
        if (tx_start1) begin
          chk("one_tx_data", 32'(tx_data1), 32'(exp_byte(line1)));
          line1++; n_st1++;
        end
        if (done1) begin
          chk("one_bytes", line1, HDR + 1);
          line1 = 0; n_done1++;
        end
      end
    end
  end

  task automatic wait_idx(input int n);
    bit seen = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge i_Clk);
      if (line_idx >= n) begin seen = 1; break; end
    end
    chk("reach_byte", 32'(seen), 1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge i_Clk);
      if (done) begin seen = 1; break; end
    end
    chk("frame_done_seen", 32'(seen), 1);
  endtask

  task automatic pulse_ready(input int w);
    @(posedge i_Clk); #1 ready = 1'b1;
    repeat (w) @(posedge i_Clk);
    #1 ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  int s0, d0;

  initial begin
    i_Rst = 1'b1; ready = 1'b0; ready1 = 1'b0; ext_busy = 1'b0;
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    chk("reset_outs", 32'({rd_en, rd_addr, tx_start, tx_data, busy, done}), 0);
    chk("reset_outs_one", 32'({rd_en1, rd_addr1, tx_start1, tx_data1, busy1, done1}), 0);
    @(posedge i_Clk); #1 i_Rst = 1'b0;
    idle($urandom_range(20, 1));

    // Full frame with first-byte latency check
    s0 = n_start; d0 = n_done;
    ready = 1'b1;
    @(posedge i_Clk); #1 ready = 1'b0;
    @(negedge i_Clk);
    chk("lat_rd_en_n1", 32'(rd_en), 32'(HDR == 0));
    chk("lat_busy_n1", 32'(busy), 1);
    @(negedge i_Clk);
    @(negedge i_Clk);
    chk("lat_start_n3", 32'(tx_start), 32'(HDR == 0));
    wait_done();
    @(negedge i_Clk);
    chk("busy_after_done", 32'(busy), 0);
    chk("frames_a", n_done - d0, 1);
    chk("starts_a", n_start - s0, TOTAL);

    // Frame-ready pulse mid-frame is ignored
    idle($urandom_range(20, 1));
    s0 = n_start; d0 = n_done;
    pulse_ready($urandom_range(3, 1));
    wait_idx(50);
    pulse_ready($urandom_range(4, 1));
    wait_done();
    idle(150);
    chk("no_queued_frame", n_start - s0, TOTAL);
    chk("frames_b", n_done - d0, 1);
    chk("idle_busy_b", 32'(busy), 0);

    // Reset mid-frame
    s0 = n_start; d0 = n_done;
    pulse_ready(1);
    wait_idx(100);
    @(posedge i_Clk); #1 i_Rst = 1'b1;
    @(posedge i_Clk); #1 i_Rst = 1'b0;
    @(negedge i_Clk);
    chk("rst_mid_outs", 32'({rd_en, rd_addr, tx_start, tx_data, busy, done}), 0);
    idle(20);
    chk("no_done_on_rst", n_done - d0, 0);
    pulse_ready(1);
    wait_done();
    chk("restart_frame", n_done - d0, 1);

    // Tx busy from elsewhere stalls the first start
    idle(20);
    s0 = n_start; d0 = n_done;
    ext_busy = 1'b1;
    pulse_ready(1);
    idle(50);
    chk("stall_no_start", n_start - s0, 0);
    ext_busy = 1'b0;
    wait_done();
    chk("stall_starts", n_start - s0, TOTAL);

    // Frame-ready held through DONE starts the next frame straight away
    idle($urandom_range(10, 1));
    s0 = n_start; d0 = n_done;
    ready = 1'b1;
    wait_done();
    @(negedge i_Clk);
    chk("gap_busy_low", 32'(busy), 0);
    @(negedge i_Clk);
    chk("back_to_back_busy", 32'(busy), 1);
    @(posedge i_Clk); #1 ready = 1'b0;
    wait_done();
    chk("back_to_back_frames", n_done - d0, 2);
    chk("back_to_back_starts", n_start - s0, 2 * TOTAL);

    // Single-byte frame
    @(posedge i_Clk); #1 ready1 = 1'b1;
    @(posedge i_Clk); #1 ready1 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_Clk);
      if (n_done1 != 0) break;
    end
    idle(3);
    chk("one_reads", n_rd1, 1);
    chk("one_starts", n_st1, HDR + 1);
    chk("one_done", n_done1, 1);
    chk("one_busy_after", 32'(busy1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
